weight_fetch: RTL and testbench
===============================

# weight_fetch

Read-side sequencer for a layer's weight memory. On `start` it walks the memory linearly from `BASE_ADDR`, issuing one-cycle-latency reads through the memory's `read_enable`/`read_addr`/`read_data` port. It streams the returned weights to the neuron MAC over a valid/ready interface, tagging neuron and layer boundaries. A 2-entry buffer absorbs the fixed read latency, so backpressure never drops or duplicates a weight.

## Interface
- `NUM_INPUTS`, 5: weights per neuron
- `NUM_NEURONS`, 1: neurons in the layer
- `ADDR_WIDTH`, 10: memory address width
- `DATA_WIDTH`, 16: weight width
- `BASE_ADDR`, 0: address of the first weight
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a layer fetch; sampled only in IDLE
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `mem_read_enable` out 1: read strobe to weight memory
- `mem_read_addr` out ADDR_WIDTH: read address
- `mem_read_data` in DATA_WIDTH: memory data, valid the cycle after the strobe
- `w_valid` out 1: weight available
- `w_ready` in 1: MAC accepts the weight
- `w_data` out DATA_WIDTH: weight
- `w_last_input` out 1: weight is the last input of its neuron
- `w_last_neuron` out 1: weight is the final weight of the layer

## Operation
- Total weights per run: N = NUM_NEURONS*NUM_INPUTS. Elaboration error if BASE_ADDR+N > 2**ADDR_WIDTH.
- States: IDLE, FETCH, DRAIN.
  - IDLE to FETCH on `start`. `start` is ignored in FETCH and DRAIN.
  - FETCH to DRAIN in the cycle that issues the last address.
  - DRAIN to IDLE when the buffer is empty, no read is in flight, and the last handshake has completed. `done` pulses in that transition cycle.
- Address counter: resets to BASE_ADDR on entry to FETCH and increments by 1 per issued read. It never wraps within a run.
- Issue rule: `mem_read_enable` = FETCH && (occupancy + inflight − pop) < 2.
  - `pop` = `w_valid && w_ready` this cycle.
  - `inflight` is 1 in the cycle after a strobe. The returning `mem_read_data` is written into the buffer at the end of that cycle.
- Buffer: 2-entry FIFO. It stores {data, last_input, last_neuron}. Tag flags come from input and neuron counters running alongside the address counter.
- `w_valid` = buffer not empty. The outputs come from the buffer head and are held stable while `w_valid && !w_ready`.
- Simultaneous push and pop on a full or empty buffer is legal and keeps occupancy unchanged.
- Reset values: `busy`=0, `done`=0, `mem_read_enable`=0, `mem_read_addr`=BASE_ADDR, `w_valid`=0, `w_data`=0, both `w_last_*`=0, state IDLE.
- Reset mid-run:
  - The buffer and counters are cleared and any in-flight read is discarded.
  - No `done` is generated.
  - The next `start` fetches from BASE_ADDR.

## Timing
- Latency: `start` sampled high at edge T gives `busy`=1 and the first strobe (addr BASE) in cycle T+1. First `w_valid` is in cycle T+3.
- With `w_ready` held high, throughput is 1 weight/cycle.
  - Handshakes occur in cycles T+3..T+2+N.
  - `done` pulses in T+3+N, with `busy`=0 from that cycle.
- With `w_ready` low, at most 2 reads are ever unconsumed, counting buffered plus in-flight.
- `done` and `busy` are never high together.

## Configuration
- `WEIGHT_FETCH_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` [31:0].
  - It counts cycles with `w_valid && !w_ready` during a run and saturates at all-ones.
  - It clears on accepted `start` and on `rst`, and holds its value after `done`.
- `WEIGHT_FETCH_STALL_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- The shared package `nn_pkg` holds:
  - the `fetch_state_t` enum {IDLE, FETCH, DRAIN};
  - the `weight_t` typedef, logic [DATA_WIDTH-1:0], defaulting to 16;
  - the tagged-entry struct {weight_t data; logic last_input; logic last_neuron}.
- Sub-module `weight_fetch_fifo`: 2-entry synchronous FIFO with push/pop, full/empty, occupancy and synchronous reset. It is instantiated once.

## Test plan
Bench config: NUM_INPUTS=5, NUM_NEURONS=2, BASE_ADDR=0, memory model with 1-cycle latency where word[i] = 0x0100+i.
- Streaming: `start` pulse at T with `w_ready`=1.
  - Expect w_data 0x0100..0x0109 in T+3..T+12.
  - `w_last_input` high on 0x0104 and 0x0109; `w_last_neuron` high only on 0x0109.
  - `done` pulses at T+13.
- Backpressure: `w_ready` toggles with a 3-low/1-high pattern.
  - The same 10-word sequence arrives with no loss or duplication.
  - Outstanding reads never exceed 2, and `w_data` is stable while stalled.
- Ignored start: pulse `start` again at T+5 during a run. It has no effect; exactly 10 weights and one `done` are produced.
- Reset mid-run: assert `rst` at T+6 for one cycle.
  - All outputs return to their reset values and no `done` occurs.
  - A fresh `start` then yields 0x0100 first.
- Stall counter (`WEIGHT_FETCH_STALL_CNT_EN` defined): hold `w_ready`=0 for the first 4 cycles that `w_valid` is high, then hold it at 1. After `done`, `stall_cycles`=4.
- Back-to-back: `start` is asserted in the `done` cycle and is ignored, since the block is not yet IDLE. `start` in the following cycle begins a second full run from 0x0100.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared types for the weight fetch path.
//   fetch_state_t : sequencer states (IDLE, FETCH, DRAIN)
//   weight_t      : one weight word, WEIGHT_WIDTH bits wide (16 by default)
//   fetch_entry_t : tagged buffer entry {data, last_input, last_neuron}
//   pending_reads : reads still unconsumed after this cycle's pop
package nn_pkg;

  localparam int WEIGHT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef logic [WEIGHT_WIDTH-1:0] weight_t;

  typedef struct packed {
    weight_t data;
    logic    last_input;
    logic    last_neuron;
  } fetch_entry_t;

  // Buffered plus in-flight reads, minus the entry handed out this cycle.
  // A pop is only possible with occupancy >= 1, so the result never underflows.
  function automatic logic [2:0] pending_reads(input logic [1:0] occupancy,
                                               input logic       inflight,
                                               input logic       pop);
    return {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// weight_fetch_fifo: 2-entry synchronous FIFO holding tagged weights.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write an entry at the tail
//   pop               : drop the head entry
//   head_data         : current head entry (valid when !empty)
//   full, empty       : status flags
//   occupancy         : number of stored entries (0..2)
// Push and pop in the same cycle leave occupancy unchanged. The caller
// never pushes into a full FIFO without popping, nor pops an empty one.
module weight_fetch_fifo
  import nn_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign occupancy = count_q;

endmodule

// File: rtl/weight_fetch.sv
// weight_fetch: read-side sequencer for a layer's weight memory.
// On start it walks NUM_NEURONS*NUM_INPUTS words from BASE_ADDR through a
// one-cycle-latency read port and streams them over valid/ready, tagging
// the last input of each neuron and the last weight of the layer. A 2-entry
// buffer absorbs the read latency so backpressure never loses a weight.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a layer fetch (only honoured in IDLE)
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   mem_read_enable   : read strobe, mem_read_addr : read address
//   mem_read_data     : memory data, valid the cycle after the strobe
//   w_valid, w_ready  : weight handshake
//   w_data, w_last_input, w_last_neuron : head weight and its tags
//   stall_cycles      : only with WEIGHT_FETCH_STALL_CNT_EN defined; counts
//                       w_valid && !w_ready cycles during a run, saturating
module weight_fetch
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = 5,
  parameter int NUM_NEURONS = 1,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last_input,
  output logic                  w_last_neuron
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int N       = NUM_NEURONS * NUM_INPUTS;
  localparam int IN_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int NEU_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ENTRY_W = DATA_WIDTH + 2;

  if ((longint'(BASE_ADDR) + longint'(N)) > (longint'(1) << ADDR_WIDTH)) begin : g_range_check
    $error("weight_fetch: BASE_ADDR + NUM_NEURONS*NUM_INPUTS exceeds the address space");
  end

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [IN_W-1:0]        in_cnt_q, in_cnt_d;
  logic [NEU_W-1:0]       neu_cnt_q, neu_cnt_d;
  logic                   inflight_q, inflight_d;
  logic                   tag_li_q, tag_li_d;
  logic                   tag_ln_q, tag_ln_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   read_en;
  logic                   pop;
  logic                   cnt_last_input;
  logic                   cnt_last_neuron;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [1:0]             fifo_occ;
  logic [ENTRY_W-1:0]     fifo_head;

  assign cnt_last_input  = (in_cnt_q == IN_W'(NUM_INPUTS - 1));
  assign cnt_last_neuron = (neu_cnt_q == NEU_W'(NUM_NEURONS - 1));
  assign w_valid         = ~fifo_empty;
  assign pop             = w_valid & w_ready;
  // Issue only while buffer + in-flight reads stay within the 2 slots.
  assign read_en         = (state_q == FETCH) &&
                           (pending_reads(fifo_occ, inflight_q, pop) < 3'd2);

  // The returning read lands in the buffer together with the tags captured
  // at issue time.
  weight_fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({mem_read_data, tag_li_q, tag_ln_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // Sequencer next-state, address/tag counters and status flags.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    in_cnt_d   = in_cnt_q;
    neu_cnt_d  = neu_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = read_en;
    tag_li_d   = cnt_last_input;
    tag_ln_d   = cnt_last_input & cnt_last_neuron;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          addr_d    = ADDR_WIDTH'(BASE_ADDR);
          in_cnt_d  = '0;
          neu_cnt_d = '0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (read_en) begin
          // The address is held on the final issue so it never wraps.
          if (cnt_last_input && cnt_last_neuron) begin
            state_d = DRAIN;
          end else if (cnt_last_input) begin
            addr_d    = addr_q + ADDR_WIDTH'(1);
            in_cnt_d  = '0;
            neu_cnt_d = neu_cnt_q + NEU_W'(1);
          end else begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            in_cnt_d = in_cnt_q + IN_W'(1);
          end
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // done is registered: the final handshake schedules it, and the
        // state leaves DRAIN only at the end of the done cycle, so a start
        // in that cycle is still ignored.
        if (done_q) begin
          state_d = IDLE;
        end else if (pop && !fifo_full && !inflight_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= ADDR_WIDTH'(BASE_ADDR);
      in_cnt_q   <= '0;
      neu_cnt_q  <= '0;
      inflight_q <= 1'b0;
      tag_li_q   <= 1'b0;
      tag_ln_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      in_cnt_q   <= in_cnt_d;
      neu_cnt_q  <= neu_cnt_d;
      inflight_q <= inflight_d;
      tag_li_q   <= tag_li_d;
      tag_ln_q   <= tag_ln_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_read_enable = read_en;
  assign mem_read_addr   = addr_q;
  assign w_data          = fifo_head[ENTRY_W-1:2];
  assign w_last_input    = fifo_head[1];
  assign w_last_neuron   = fifo_head[0];

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter: cleared by an accepted start, saturates at all-ones.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = 32'd0;
    end else if (busy_q && w_valid && !w_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: NUM_INPUTS=5, NUM_NEURONS=2, BASE_ADDR=0,
// memory word[i] = 0x0100+i with one cycle of read latency.
module tb_weight_fetch;
  import nn_pkg::*;

  localparam int NW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_read_enable;
  logic [9:0]  mem_read_addr;
  logic [15:0] mem_read_data = 16'h0000;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        w_last_input;
  logic        w_last_neuron;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  weight_fetch #(
    .NUM_INPUTS  (5),
    .NUM_NEURONS (2),
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (16),
    .BASE_ADDR   (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .mem_read_enable (mem_read_enable),
    .mem_read_addr   (mem_read_addr),
    .mem_read_data   (mem_read_data),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .w_last_input    (w_last_input),
    .w_last_neuron   (w_last_neuron)
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read_enable) begin
      mem_read_data <= 16'h0100 + {6'd0, mem_read_addr};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  fetch_entry_t exp_tab [NW];
  fetch_entry_t sb_q [$];

  // Ready generator: 0 = always ready, 1 = 3 low / 1 high, 2 = low for the
  // first 4 valid cycles then high.
  int ready_mode = 0;
  int phase      = 0;
  int vcnt       = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: w_ready = 1'b1;
      1: begin
        w_ready = (phase % 4 == 3);
        phase++;
      end
      2: begin
        if (vcnt < 4) begin
          w_ready = 1'b0;
          if (w_valid) vcnt++;
        end else begin
          w_ready = 1'b1;
        end
      end
      default: w_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard compare on handshakes plus per-cycle invariants.
  logic         prev_stall = 1'b0;
  logic [17:0]  prev_head  = '0;
  logic         busy_prev  = 1'b0;
  logic         en_prev    = 1'b0;
  int issued = 0, accepted = 0;
  int run_hs = 0, run_first_hs = -1, run_last_hs = -1;
  int done_cnt = 0, done_cyc = -1, busy_rise_cyc = -1, en_rise_cyc = -1;
  fetch_entry_t exp_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      issued     = 0;
      accepted   = 0;
      busy_prev  = 1'b0;
      en_prev    = 1'b0;
      sb_q.delete();
    end else begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy && !busy_prev) begin
        busy_rise_cyc = cyc;
        run_hs        = 0;
      end
      if (mem_read_enable && !en_prev) en_rise_cyc = cyc;
      if (prev_stall) begin
        check("stall_hold", {13'd0, w_valid, w_data, w_last_input, w_last_neuron},
              {13'd0, 1'b1, prev_head});
      end
      if (mem_read_enable) issued++;
      if (w_valid && w_ready) begin
        accepted++;
        if (run_hs == 0) run_first_hs = cyc;
        run_last_hs = cyc;
        run_hs++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_weight", {14'd0, w_data, w_last_input, w_last_neuron}, 32'hFFFF_FFFF);
        end else begin
          exp_e = sb_q.pop_front();
          check("sb_weight", {14'd0, w_data, w_last_input, w_last_neuron}, {14'd0, exp_e});
        end
      end
      if (busy) check("outstanding_le2", {31'd0, (issued - accepted) <= 2}, 32'd1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = w_valid & ~w_ready;
      prev_head  = {w_data, w_last_input, w_last_neuron};
      busy_prev  = busy;
      en_prev    = mem_read_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(output int c);
    start = 1'b1;
    c = cyc;
    for (int i = 0; i < NW; i++) sb_q.push_back(exp_tab[i]);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int t = 0;
    while (done_cnt == base && t < 300) begin
      tick();
      t++;
    end
    check({name, "_done_seen"}, {31'd0, done_cnt > base}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  {31'd0, busy}, 32'd0);
    check({name, "_done"},  {31'd0, done}, 32'd0);
    check({name, "_ren"},   {31'd0, mem_read_enable}, 32'd0);
    check({name, "_raddr"}, {22'd0, mem_read_addr}, 32'd0);
    check({name, "_valid"}, {31'd0, w_valid}, 32'd0);
    check({name, "_wdata"}, {16'd0, w_data}, 32'd0);
    check({name, "_tags"},  {30'd0, w_last_input, w_last_neuron}, 32'd0);
  endtask

  int c, c2, base;

  initial begin
    exp_tab[0] = '{data: 16'h0100, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[1] = '{data: 16'h0101, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[2] = '{data: 16'h0102, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[3] = '{data: 16'h0103, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[4] = '{data: 16'h0104, last_input: 1'b1, last_neuron: 1'b0};
    exp_tab[5] = '{data: 16'h0105, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[6] = '{data: 16'h0106, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[7] = '{data: 16'h0107, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[8] = '{data: 16'h0108, last_input: 1'b0, last_neuron: 1'b0};
    exp_tab[9] = '{data: 16'h0109, last_input: 1'b1, last_neuron: 1'b1};

    rst     = 1'b1;
    start   = 1'b0;
    w_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Streaming with w_ready held high.
    ready_mode = 0;
    base = done_cnt;
    issue_start(c);
    wait_done(base, "stream");
    check("stream_busy_rise", busy_rise_cyc, c + 1);
    check("stream_first_strobe", en_rise_cyc, c + 1);
    check("stream_first_hs", run_first_hs, c + 3);
    check("stream_last_hs", run_last_hs, c + 12);
    check("stream_hs_count", run_hs, NW);
    check("stream_done_cycle", done_cyc, c + 13);
    check("stream_done_pulse", {31'd0, done}, 32'd0);
    check("stream_idle_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();

    // Backpressure: 3 cycles low, 1 high.
    phase = 0;
    ready_mode = 1;
    base = done_cnt;
    issue_start(c);
    wait_done(base, "bp");
    check("bp_hs_count", run_hs, NW);
    check("bp_sb_empty", sb_q.size(), 0);
    ready_mode = 0;
    repeat (3) tick();

    // Extra start during a run is ignored.
    base = done_cnt;
    issue_start(c);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(base, "ign");
    repeat (20) tick();
    check("ign_hs_count", run_hs, NW);
    check("ign_done_count", done_cnt, base + 1);
    check("ign_sb_empty", sb_q.size(), 0);

    // Reset in the middle of a run.
    issue_start(c);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    base = done_cnt;
    repeat (20) tick();
    check("midrst_no_done", done_cnt, base);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    issue_start(c);
    wait_done(base, "midrst_rerun");
    check("midrst_rerun_first_hs", run_first_hs, c + 3);
    check("midrst_rerun_hs_count", run_hs, NW);
    repeat (3) tick();

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    // Stall counter: ready low for the first 4 valid cycles.
    vcnt = 0;
    ready_mode = 2;
    base = done_cnt;
    issue_start(c);
    wait_done(base, "stall");
    repeat (2) tick();
    check("stall_cycles", stall_cycles, 32'd4);
    check("stall_hs_count", run_hs, NW);
    ready_mode = 0;
    repeat (3) tick();
`endif

    // Back-to-back: start in the done cycle is ignored, the next one runs.
    ready_mode = 0;
    base = done_cnt;
    issue_start(c);
    begin
      int t = 0;
      while (!done && t < 300) begin
        tick();
        t++;
      end
      check("b2b_first_done", {31'd0, done}, 32'd1);
    end
    start = 1'b1;
    tick();
    base = done_cnt;
    issue_start(c2);
    wait_done(base, "b2b");
    check("b2b_first_hs", run_first_hs, c2 + 3);
    check("b2b_hs_count", run_hs, NW);
    check("b2b_done_cycle", done_cyc, c2 + 13);
    repeat (5) tick();
    check("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
